// File: rtl/secded_dec_pipe_if.sv
// Codeword in / corrected word out bundle for secded_dec_pipe, plus error counter taps.
// slave is the decoder's view, master the driver's.
interface secded_dec_pipe_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  localparam int R = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 :
                     (DATA_W <= 120) ? 7 : 8;
  localparam int CODE_W = DATA_W + R + 1;

  logic              enable;
  logic              o_ready;
  logic [CODE_W-1:0] i_code;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_err_corr;
  logic              o_err_detec;
  logic              o_err_fatal;
  logic [R-1:0]      o_err_pos;
  logic              i_cnt_clr;
  logic [CNT_W-1:0]  o_cnt_corr;
  logic [CNT_W-1:0]  o_cnt_detec;

  modport slave (
    input  enable, i_code, i_ready, i_cnt_clr,
    output o_ready, o_valid, o_data, o_err_corr, o_err_detec, o_err_fatal,
           o_err_pos, o_cnt_corr, o_cnt_detec
  );

  modport master (
    output enable, i_code, i_ready, i_cnt_clr,
    input  o_ready, o_valid, o_data, o_err_corr, o_err_detec, o_err_fatal,
           o_err_pos, o_cnt_corr, o_cnt_detec
  );
endinterface

// File: rtl/secded_dec_pipe.sv
// SECDED Hamming decoder; ECC_DEC_ERR_CNT_EN adds error counters and last-corrected position.
// Latency: 2 cycles accept-to-o_valid (S1 syndrome/parity, S2 correction/flags), 1 word/cycle.
// Backpressure: each stage advances when empty or downstream advances; stalled output holds stable.
module secded_dec_pipe #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  secded_dec_pipe_if.slave bus
);
  localparam int R = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 :
                     (DATA_W <= 120) ? 7 : 8;
  localparam int CODE_W = DATA_W + R + 1;
  localparam logic [R-1:0] MAX_POS = R'(CODE_W - 1);

  // Hamming position of data bit k: k-th non-power-of-2 position from 3 upward.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int j = 3; j < CODE_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (n == k) pos = j;
        n++;
      end
    end
    return pos;
  endfunction

  logic [CODE_W-1:0] code_in;
  logic [R-1:0]      syn_in;
  logic              par_in;

  logic              s1_vld;
  logic [CODE_W-1:0] s1_code;
  logic [R-1:0]      s1_syn;
  logic              s1_par;

  logic              s2_vld;
  logic [DATA_W-1:0] s2_data;
  logic              s2_corr;
  logic              s2_detec;
  logic              s2_fatal;
  logic [R-1:0]      s2_syn;

  logic              s1_adv;
  logic              s2_adv;
  logic              in_acc;
  logic              out_acc;

  logic [CODE_W-1:0] fix_code;
  logic [DATA_W-1:0] fix_data;
  logic              corr_d;
  logic              detec_d;
  logic              fatal_d;

  assign code_in = bus.i_code;

  always_comb begin
    syn_in = '0;
    for (int j = 1; j < CODE_W; j++) begin
      if (code_in[j]) syn_in = syn_in ^ R'(j);
    end
    par_in = ^code_in;
  end

  // Syndrome above the top position cannot point at a real bit: treat as fatal, not correctable.
  always_comb begin
    corr_d   = s1_par && (s1_syn <= MAX_POS);
    fatal_d  = s1_par && (s1_syn > MAX_POS);
    detec_d  = !s1_par && (s1_syn != '0);
    fix_code = s1_code;
    if (corr_d) fix_code = s1_code ^ ({{(CODE_W-1){1'b0}}, 1'b1} << s1_syn);
    fix_data = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fix_data[k] = fix_code[data_pos(k)];
    end
  end

  assign s2_adv      = !s2_vld || bus.i_ready;
  assign s1_adv      = !s1_vld || s2_adv;
  assign bus.o_ready = reset_n && s1_adv;
  assign in_acc      = bus.enable && bus.o_ready;
  assign out_acc     = s2_vld && bus.i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_data  <= '0;
      s2_corr  <= 1'b0;
      s2_detec <= 1'b0;
      s2_fatal <= 1'b0;
      s2_syn   <= '0;
    end else begin
      if (s1_adv) s1_vld <= in_acc;
      if (in_acc) begin
        s1_code <= code_in;
        s1_syn  <= syn_in;
        s1_par  <= par_in;
      end
      if (s2_adv) s2_vld <= s1_vld;
      if (s2_adv && s1_vld) begin
        s2_data  <= fix_data;
        s2_corr  <= corr_d;
        s2_detec <= detec_d;
        s2_fatal <= fatal_d;
        s2_syn   <= s1_syn;
      end
    end
  end

  assign bus.o_valid     = s2_vld;
  assign bus.o_data      = s2_data;
  assign bus.o_err_corr  = s2_vld && s2_corr;
  assign bus.o_err_detec = s2_vld && s2_detec;
  assign bus.o_err_fatal = s2_vld && s2_fatal;

`ifdef ECC_DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_detec;
  logic [R-1:0]     err_pos;

  // Counters move on consumption, not on S2 load, so a stalled word is counted once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_corr  <= '0;
      cnt_detec <= '0;
      err_pos   <= '0;
    end else begin
      if (out_acc && s2_corr) err_pos <= s2_syn;
      if (bus.i_cnt_clr) begin
        cnt_corr  <= '0;
        cnt_detec <= '0;
      end else if (out_acc) begin
        if (s2_corr && (cnt_corr != CNT_MAX)) cnt_corr <= cnt_corr + 1'b1;
        if ((s2_detec || s2_fatal) && (cnt_detec != CNT_MAX)) cnt_detec <= cnt_detec + 1'b1;
      end
    end
  end

  assign bus.o_cnt_corr  = cnt_corr;
  assign bus.o_cnt_detec = cnt_detec;
  assign bus.o_err_pos   = err_pos;
`else
  logic unused_cnt;
  assign unused_cnt      = ^{bus.i_cnt_clr, out_acc, s2_syn};
  assign bus.o_cnt_corr  = '0;
  assign bus.o_cnt_detec = '0;
  assign bus.o_err_pos   = '0;
`endif
endmodule

// File: tb/tb_secded_dec_pipe.sv
// Randomised + directed bench for secded_dec_pipe against a positional Hamming model.
module tb_secded_dec_pipe;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 2;
  localparam int R       = 7;
  localparam int CODE_W  = 72;
  localparam int CNT_MAX = 3;
`ifdef ECC_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              detec;
    logic              fatal;
    logic [R-1:0]      pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  secded_dec_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [CODE_W-1:0] c);
    exp_t e;
    int   s;
    int   k;
    logic p;
    s = 0;
    p = 1'b0;
    for (int j = 0; j < CODE_W; j++) begin
      if (c[j]) begin
        s = s ^ j;
        p = ~p;
      end
    end
    e = '0;
    if (p && s < CODE_W) begin
      e.corr = 1'b1;
      e.pos  = R'(s);
      c[s]   = ~c[s];
    end else if (p) begin
      e.fatal = 1'b1;
    end else if (s != 0) begin
      e.detec = 1'b1;
    end
    k = 0;
    for (int j = 1; j < CODE_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        e.data[k] = c[j];
        k++;
      end
    end
    return e;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    int s;
    int k;
    c = '0;
    s = 0;
    k = 0;
    for (int j = 1; j < CODE_W; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j] = d[k];
        if (d[k]) s = s ^ j;
        k++;
      end
    end
    for (int b = 0; b < R; b++) c[1 << b] = s[b];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [CODE_W-1:0] rand_code();
    logic [CODE_W-1:0] c;
    int a;
    int b;
    c = encode({$urandom(), $urandom()});
    case ($urandom_range(3, 0))
      0: c = c;
      1: begin
        a = $urandom_range(CODE_W - 1, 0);
        c[a] = ~c[a];
      end
      2: begin
        a = $urandom_range(CODE_W - 1, 0);
        b = (a + $urandom_range(CODE_W - 1, 1)) % CODE_W;
        c[a] = ~c[a];
        c[b] = ~c[b];
      end
      default: c = CODE_W'({$urandom(), $urandom(), $urandom()});
    endcase
    return c;
  endfunction

  task automatic apply_reset();
    bus.enable    = 1'b0;
    bus.i_code    = '0;
    bus.i_ready   = 1'b1;
    bus.i_cnt_clr = 1'b0;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one word for one cycle; returns at the negedge where it should be on the output.
  task automatic issue(input logic [CODE_W-1:0] c, output logic early_vld);
    @(posedge clk);
    #1 bus.enable = 1'b1;
    bus.i_code = c;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    @(negedge clk);
    early_vld = bus.o_valid;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enable    = 1'b1;
    bus.i_code    = 72'h1000;
    bus.i_ready   = 1'b1;
    bus.i_cnt_clr = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_o_ready: got %b expected 0", bus.o_ready); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b expected 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== '0) begin n_fail++; $display("FAIL reset_o_data: got %h expected 0", bus.o_data); end
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    n_checks++;
    if ({bus.o_cnt_corr, bus.o_cnt_detec, bus.o_err_pos} !== '0) begin
      n_fail++; $display("FAIL reset_cnt_pos: got %h expected 0", {bus.o_cnt_corr, bus.o_cnt_detec, bus.o_err_pos});
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL release_o_ready: got %b expected 1", bus.o_ready); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL release_no_output: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_clean();
    logic ev;
    apply_reset();
    issue(72'h0, ev);
    n_checks++;
    if (ev !== 1'b0) begin n_fail++; $display("FAIL clean_early_valid: got %b expected 0", ev); end
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL clean_latency: got %b expected 1", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== '0) begin n_fail++; $display("FAIL clean_data: got %h expected 0", bus.o_data); end
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b000) begin
      n_fail++; $display("FAIL clean_flags: got %b expected 000", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL clean_no_dup: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_corr();
    logic ev;
    apply_reset();
    issue(72'h1000, ev);
    n_checks++;
    if (bus.o_data !== '0) begin n_fail++; $display("FAIL corr12_data: got %h expected 0", bus.o_data); end
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b100) begin
      n_fail++; $display("FAIL corr12_flags: got %b expected 100", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_err_pos !== (CNT_EN ? 7'd12 : 7'd0)) begin
      n_fail++; $display("FAIL corr12_pos: got %0d expected %0d", bus.o_err_pos, CNT_EN ? 12 : 0);
    end
    n_checks++;
    if (bus.o_cnt_corr !== (CNT_EN ? 2'd1 : 2'd0)) begin
      n_fail++; $display("FAIL corr12_cnt: got %0d expected %0d", bus.o_cnt_corr, CNT_EN ? 1 : 0);
    end
    issue(72'h1, ev);
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b100) begin
      n_fail++; $display("FAIL corr0_flags: got %b expected 100", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    n_checks++;
    if (bus.o_err_pos !== (CNT_EN ? 7'd12 : 7'd0)) begin
      n_fail++; $display("FAIL corr0_pos_hold: got %0d expected %0d", bus.o_err_pos, CNT_EN ? 12 : 0);
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_err_pos !== 7'd0) begin n_fail++; $display("FAIL corr0_pos: got %0d expected 0", bus.o_err_pos); end
    n_checks++;
    if (bus.o_cnt_corr !== (CNT_EN ? 2'd2 : 2'd0)) begin
      n_fail++; $display("FAIL corr0_cnt: got %0d expected %0d", bus.o_cnt_corr, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_detec_fatal();
    logic ev;
    logic [CODE_W-1:0] fc;
    exp_t e;
    apply_reset();
    issue(72'h50000, ev);
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b010) begin
      n_fail++; $display("FAIL detec_flags: got %b expected 010", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    n_checks++;
    if (bus.o_data !== 64'h1000) begin n_fail++; $display("FAIL detec_data: got %h expected 1000", bus.o_data); end
    @(negedge clk);
    n_checks++;
    if (bus.o_cnt_detec !== (CNT_EN ? 2'd1 : 2'd0)) begin
      n_fail++; $display("FAIL detec_cnt: got %0d expected %0d", bus.o_cnt_detec, CNT_EN ? 1 : 0);
    end
    fc = 72'h14000000000000002;
    e  = model(fc);
    issue(fc, ev);
    n_checks++;
    if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b001) begin
      n_fail++; $display("FAIL fatal_flags: got %b expected 001", {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
    end
    n_checks++;
    if (bus.o_data !== e.data) begin n_fail++; $display("FAIL fatal_data: got %h expected %h", bus.o_data, e.data); end
    @(negedge clk);
    n_checks++;
    if (bus.o_cnt_detec !== (CNT_EN ? 2'd2 : 2'd0)) begin
      n_fail++; $display("FAIL fatal_cnt: got %0d expected %0d", bus.o_cnt_detec, CNT_EN ? 2 : 0);
    end
    n_checks++;
    if ({bus.o_cnt_corr, bus.o_err_pos} !== '0) begin
      n_fail++; $display("FAIL fatal_no_corr_side: got %h expected 0", {bus.o_cnt_corr, bus.o_err_pos});
    end
  endtask

  task automatic test_back_to_back();
    logic [CODE_W-1:0] w[4];
    exp_t q[$];
    exp_t e;
    int   sent;
    int   got;
    bit   saw_block;
    bit   held;
    logic [DATA_W+R+2:0] snap;
    apply_reset();
    for (int i = 0; i < 4; i++) w[i] = rand_code();
    sent = 0;
    got = 0;
    saw_block = 1'b0;
    held = 1'b0;
    snap = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1 bus.enable = (sent < 4);
      bus.i_code  = w[(sent < 4) ? sent : 0];
      bus.i_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (bus.o_valid !== 1'b1 || {bus.o_data, bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal, bus.o_err_pos} !== snap) begin
          n_fail++; $display("FAIL b2b_hold: got %b/%h expected 1/%h", bus.o_valid,
            {bus.o_data, bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal, bus.o_err_pos}, snap);
        end
      end
      held = bus.o_valid && !bus.i_ready;
      snap = {bus.o_data, bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal, bus.o_err_pos};
      if (held && !bus.o_ready) saw_block = 1'b1;
      if (bus.o_valid && bus.i_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_word: got data %h expected none", bus.o_data);
        end else begin
          e = q.pop_front();
          if (bus.o_data !== e.data || {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== {e.corr, e.detec, e.fatal}) begin
            n_fail++; $display("FAIL b2b_word%0d: got %h/%b expected %h/%b", got, bus.o_data,
              {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal}, e.data, {e.corr, e.detec, e.fatal});
          end
        end
        got++;
      end
      if (bus.enable && bus.o_ready) begin
        q.push_back(model(w[sent]));
        sent++;
      end
    end
    n_checks++;
    if (saw_block !== 1'b1) begin n_fail++; $display("FAIL b2b_o_ready_drop: got %b expected 1", saw_block); end
    n_checks++;
    if (got != 4 || sent != 4) begin n_fail++; $display("FAIL b2b_count: got %0d/%0d expected 4/4", got, sent); end
  endtask

  task automatic test_random_stream();
    exp_t q[$];
    exp_t e;
    int   sent;
    int   cyc;
    int   ec;
    int   ed;
    logic [R-1:0] epos;
    localparam int N = 400;
    apply_reset();
    sent = 0;
    cyc  = 0;
    ec   = 0;
    ed   = 0;
    epos = '0;
    while ((sent < N || q.size() != 0) && cyc < 4000) begin
      @(posedge clk);
      #1 bus.enable = (sent < N) && ($urandom_range(3, 0) != 0);
      bus.i_code    = rand_code();
      bus.i_ready   = ($urandom_range(9, 0) < 7);
      bus.i_cnt_clr = ($urandom_range(49, 0) == 0);
      @(negedge clk);
      n_checks++;
      if (bus.o_cnt_corr !== (CNT_EN ? CNT_W'(ec) : CNT_W'(0)) || bus.o_cnt_detec !== (CNT_EN ? CNT_W'(ed) : CNT_W'(0))) begin
        n_fail++; $display("FAIL rnd_counters@%0d: got %0d/%0d expected %0d/%0d", cyc,
          bus.o_cnt_corr, bus.o_cnt_detec, CNT_EN ? ec : 0, CNT_EN ? ed : 0);
      end
      n_checks++;
      if (bus.o_err_pos !== (CNT_EN ? epos : R'(0))) begin
        n_fail++; $display("FAIL rnd_err_pos@%0d: got %0d expected %0d", cyc, bus.o_err_pos, CNT_EN ? epos : R'(0));
      end
      if (!bus.o_valid) begin
        n_checks++;
        if ({bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== 3'b000) begin
          n_fail++; $display("FAIL rnd_idle_flags@%0d: got %b expected 000", cyc, {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal});
        end
      end
      if (bus.o_valid && bus.i_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_word@%0d: got data %h expected none", cyc, bus.o_data);
        end else begin
          e = q.pop_front();
          if (bus.o_data !== e.data || {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal} !== {e.corr, e.detec, e.fatal}) begin
            n_fail++; $display("FAIL rnd_word@%0d: got %h/%b expected %h/%b", cyc, bus.o_data,
              {bus.o_err_corr, bus.o_err_detec, bus.o_err_fatal}, e.data, {e.corr, e.detec, e.fatal});
          end
          if (e.corr) epos = e.pos;
          if (!bus.i_cnt_clr) begin
            if (e.corr && ec < CNT_MAX) ec++;
            if ((e.detec || e.fatal) && ed < CNT_MAX) ed++;
          end
        end
      end
      if (bus.i_cnt_clr) begin
        ec = 0;
        ed = 0;
      end
      if (bus.enable && bus.o_ready) begin
        q.push_back(model(bus.i_code));
        sent++;
      end
      cyc++;
    end
    bus.enable    = 1'b0;
    bus.i_cnt_clr = 1'b0;
    n_checks++;
    if (cyc >= 4000) begin n_fail++; $display("FAIL rnd_timeout: got %0d pending expected 0", q.size()); end
  endtask

  task automatic test_cnt_sat_clr();
    logic ev;
    apply_reset();
    for (int i = 0; i < 5; i++) issue(encode({$urandom(), $urandom()}) ^ (72'h1 << $urandom_range(CODE_W - 1, 0)), ev);
    @(negedge clk);
    n_checks++;
    if (bus.o_cnt_corr !== (CNT_EN ? 2'd3 : 2'd0)) begin
      n_fail++; $display("FAIL cnt_saturate: got %0d expected %0d", bus.o_cnt_corr, CNT_EN ? 3 : 0);
    end
    issue(72'h1000, ev);
    bus.i_cnt_clr = 1'b1;
    @(posedge clk);
    #1 bus.i_cnt_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_cnt_corr !== 2'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %0d expected 0", bus.o_cnt_corr); end
    n_checks++;
    if (bus.o_err_pos !== (CNT_EN ? 7'd12 : 7'd0)) begin
      n_fail++; $display("FAIL cnt_clr_pos: got %0d expected %0d", bus.o_err_pos, CNT_EN ? 12 : 0);
    end
  endtask

  task automatic test_reset_mid();
    logic ev;
    int   stale;
    apply_reset();
    issue(72'h1000, ev);
    @(posedge clk);
    #1 bus.i_ready = 1'b0;
    bus.enable = 1'b1;
    bus.i_code = 72'h50000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got %b expected 1", bus.o_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_clear: got %b%b expected 00", bus.o_valid, bus.o_ready);
    end
    n_checks++;
    if ({bus.o_cnt_corr, bus.o_err_pos, bus.o_data} !== '0) begin
      n_fail++; $display("FAIL mid_state_clear: got %h expected 0", {bus.o_cnt_corr, bus.o_err_pos, bus.o_data});
    end
    bus.enable  = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_valid) stale++;
    end
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL mid_stale_words: got %0d expected 0", stale); end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.i_code    = '0;
    bus.i_ready   = 1'b1;
    bus.i_cnt_clr = 1'b0;
    test_reset();
    test_clean();
    test_corr();
    test_detec_fatal();
    test_back_to_back();
    test_random_stream();
    test_cnt_sat_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/secded_dec_pipe.md
SECDED_DEC_PIPE -- requirements
Module: secded_dec_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning data bits per word (legal 8..120).
REQ-002 SHALL have parameter CNT_W, default 16, meaning error-counter width.
REQ-003 SHALL derive R as the smallest integer with 2^R >= DATA_W+R+1, and CODE_W = DATA_W+R+1 (72 for DATA_W=64).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  input word valid.
REQ-007 o_ready  out  1  decoder accepts i_code this cycle.
REQ-008 i_code  in  [0:CODE_W-1]  received codeword.
REQ-009 i_ready  in  1  downstream accepts output.
REQ-010 o_valid  out  1  output word valid.
REQ-011 o_data  out  [0:DATA_W-1]  corrected data.
REQ-012 o_err_corr / o_err_detec / o_err_fatal  out  1 each  single corrected / double detected / out-of-range syndrome.
REQ-013 o_err_pos  out  R  Hamming position of last corrected bit.
REQ-014 i_cnt_clr  in  1  synchronous counter clear.
REQ-015 o_cnt_corr / o_cnt_detec  out  CNT_W each  corrected / uncorrectable word counts.

Function
REQ-016 Bit i of i_code SHALL be Hamming position i; bit 0 is overall parity; power-of-2 positions are check bits; data bit k occupies the k-th non-power-of-2 position, ascending from position 3.
REQ-017 Syndrome s SHALL be XOR of the indices of all set positions 1..CODE_W-1; p SHALL be XOR of all CODE_W bits.
REQ-018 Classification: s=0,p=0 clean; p=1 and s<=CODE_W-1 corrected (flip position s; s=0 means overall-parity bit); s!=0,p=0 detec; p=1 and s>CODE_W-1 fatal.
REQ-019 Exactly one of corr/detec/fatal SHALL be high when o_valid is high, or none for clean; all three SHALL be 0 when o_valid is low.
REQ-020 On detec or fatal, o_data SHALL be the uncorrected data bits.
REQ-021 Pipeline SHALL be two registered stages (S1: syndrome, parity, code; S2: corrected data, flags); latency 2 cycles from accept to o_valid with no backpressure.
REQ-022 Input accepted when enable && o_ready; output consumed when o_valid && i_ready.
REQ-023 Each stage SHALL advance when empty or the next stage advances; o_ready = !S1 full or S1 advancing; full throughput 1 word/cycle.
REQ-024 While o_valid && !i_ready, o_data, flags and o_err_pos SHALL hold stable; no word lost or duplicated.
REQ-025 o_err_pos SHALL update to s only on consumption of a corrected word, otherwise hold.
REQ-026 Counters SHALL increment by 1 on consumption of a corrected word (o_cnt_corr) or detec/fatal word (o_cnt_detec), saturating at 2^CNT_W-1.
REQ-027 i_cnt_clr SHALL zero both counters next cycle; clear wins over simultaneous increment.

Reset
REQ-028 reset_n low SHALL asynchronously empty both stages and force o_valid, o_data, all flags, o_err_pos and counters to 0; o_ready SHALL be 0 while reset_n low and 1 the first cycle after release.
REQ-029 Reset mid-operation SHALL discard in-flight words; no output for them after release.

Configuration
REQ-030 Macro ECC_DEC_ERR_CNT_EN defined: counters and o_err_pos implemented per REQ-025..027.
REQ-031 Macro undefined: counter and o_err_pos logic omitted, o_cnt_corr, o_cnt_detec, o_err_pos tied 0, i_cnt_clr ignored; all other behaviour identical.

Verification (DATA_W=64, macro defined unless stated)
REQ-032 i_code=72'h0, i_ready=1 -> 2 cycles later o_valid=1, o_data=0, no flags.
REQ-033 i_code=72'h1000 (position 12) -> o_data=0, o_err_corr=1, o_err_pos=12, o_cnt_corr=1; i_code=72'h1 -> o_err_corr=1, o_err_pos=0.
REQ-034 i_code=72'h50000 (positions 16,18) -> o_err_detec=1, o_data has data bit at position 18 set; i_code=72'h14000000000000002 (positions 64,62,1) -> o_err_fatal=1, o_cnt_detec increments.
REQ-035 Back-to-back 4 words with i_ready low cycles 3-5 -> o_ready drops with both stages full, outputs held stable, all 4 delivered in order.
REQ-036 CNT_W=2, 5 corrected words -> o_cnt_corr=3; i_cnt_clr with a corrected word consumed same cycle -> 0; reset_n pulse mid-stream -> o_valid=0, no stale word after release; macro undefined -> counters stay 0.
